// File: rtl/complex_accumulator.sv
// Sums a frame of N full-precision complex products, then rounds and narrows the sum to signed QI.QF.
// Optional build macro ACC_SAT_EN: out-of-range results clamp instead of wrap.
module complex_accumulator #(
  parameter int unsigned QI = 3,
  parameter int unsigned QF = 3,
  parameter int unsigned N  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [2*QI+2*QF:0]        in_re,
  input  logic signed [2*QI+2*QF:0]        in_im,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [QI+QF-1:0]          out_re,
  output logic signed [QI+QF-1:0]          out_im,
  output logic                             out_ovf
);

  localparam int unsigned PW = 2*QI + 2*QF + 1;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned AW = PW + CW;
  localparam int unsigned SW = AW + 1;
  localparam int unsigned RW = SW - QF;
  localparam int unsigned OW = QI + QF;

  localparam logic signed [RW-1:0] RMAX = RW'((2**(OW-1)) - 1);
  localparam logic signed [RW-1:0] RMIN = RW'(-(2**(OW-1)));
  localparam logic [CW-1:0]        LAST = CW'(N - 1);

  typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic signed [AW-1:0]  acc_re, acc_re_d, acc_im, acc_im_d;
  logic signed [AW-1:0]  sum_re, sum_im;
  logic signed [OW-1:0]  out_re_d, out_im_d;
  logic                  out_ovf_d, in_ready_d, out_valid_d;
  logic [OW:0]           nar_re, nar_im;

  // Round half toward +inf, arithmetic shift, then wrap or clamp; MSB of the result flags overflow.
  function automatic logic [OW:0] narrow(input logic signed [AW-1:0] sum);
    logic signed [SW-1:0] s;
    logic signed [RW-1:0] r;
    logic                 ovf;
    logic [OW-1:0]        v;
    s   = SW'(sum) + (SW'(1) << (QF - 1));
    r   = RW'(s >>> QF);
    ovf = (r > RMAX) || (r < RMIN);
`ifdef ACC_SAT_EN
    if (r > RMAX)      v = RMAX[OW-1:0];
    else if (r < RMIN) v = RMIN[OW-1:0];
    else               v = r[OW-1:0];
`else
    v = r[OW-1:0];
`endif
    return {ovf, v};
  endfunction

  // First beat of a frame loads rather than adds, so no clear cycle is needed.
  always_comb begin
    sum_re = ((cnt == '0) ? AW'(0) : acc_re) + AW'(in_re);
    sum_im = ((cnt == '0) ? AW'(0) : acc_im) + AW'(in_im);
    nar_re = narrow(sum_re);
    nar_im = narrow(sum_im);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ACC;
      cnt       <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_ovf   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      acc_re    <= acc_re_d;
      acc_im    <= acc_im_d;
      out_re    <= out_re_d;
      out_im    <= out_im_d;
      out_ovf   <= out_ovf_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    acc_re_d    = acc_re;
    acc_im_d    = acc_im;
    out_re_d    = out_re;
    out_im_d    = out_im;
    out_ovf_d   = out_ovf;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    case (state)
      S_ACC: begin
        if (in_valid) begin
          acc_re_d = sum_re;
          acc_im_d = sum_im;
          if (cnt == LAST) begin
            cnt_d       = '0;
            out_re_d    = nar_re[OW-1:0];
            out_im_d    = nar_im[OW-1:0];
            out_ovf_d   = nar_re[OW] | nar_im[OW];
            state_d     = S_OUT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_ACC;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

endmodule

// File: tb/tb_complex_accumulator.sv
// Directed bench for complex_accumulator at QI=3, QF=3, N=4 with hand-computed results.
module tb_complex_accumulator;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [12:0] in_re, in_im;
  logic               out_valid;
  logic               out_ready;
  logic signed [5:0]  out_re, out_im;
  logic               out_ovf;

  int checks = 0;
  int passed = 0;

  complex_accumulator #(.QI(3), .QF(3), .N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one beat at a negedge and returns on the following negedge.
  task automatic beat(input int re, input int im);
    in_valid = 1'b1;
    in_re    = 13'(re);
    in_im    = 13'(im);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic frame(input int re, input int im);
    for (int i = 0; i < 4; i++) beat(re, im);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_re !== 6'(0) || out_im !== 6'(0) || out_ovf !== 1'b0) begin
      $display("FAIL reset_outputs: valid=%b re=%0d im=%0d ovf=%b, required 0/0/0/0",
               out_valid, out_re, out_im, out_ovf);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end else passed++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat(48, -32);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        $display("FAIL basic_early: beat %0d out_valid=%b in_ready=%b, required 0/1", i, out_valid, in_ready);
      end else passed++;
    end
    beat(48, -32);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_re !== 6'(24) || out_im !== 6'(-16) || out_ovf !== 1'b0) begin
      $display("FAIL basic_result: valid=%b rdy=%b re=%0d im=%0d ovf=%b, required 1/0/24/-16/0",
               out_valid, in_ready, out_re, out_im, out_ovf);
    end else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL basic_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end else passed++;
  endtask

  task automatic test_rounding();
    frame(1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 6'(1) || out_im !== 6'(0)) begin
      $display("FAIL round_pos: valid=%b re=%0d im=%0d, required 1/1/0", out_valid, out_re, out_im);
    end else passed++;
    @(negedge clk);
    frame(-1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 6'(0) || out_ovf !== 1'b0) begin
      $display("FAIL round_neg: valid=%b re=%0d ovf=%b, required 1/0/0", out_valid, out_re, out_ovf);
    end else passed++;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic signed [5:0] exp_hi, exp_lo;
`ifdef ACC_SAT_EN
    exp_hi = 6'(31);
    exp_lo = 6'(-32);
`else
    exp_hi = 6'(-16);
    exp_lo = 6'(0);
`endif
    frame(96, 0);
    checks++;
    if (out_re !== exp_hi || out_im !== 6'(0) || out_ovf !== 1'b1) begin
      $display("FAIL ovf_pos: re=%0d im=%0d ovf=%b, required %0d/0/1", out_re, out_im, out_ovf, exp_hi);
    end else passed++;
    @(negedge clk);
    frame(-128, 0);
    checks++;
    if (out_re !== exp_lo || out_ovf !== 1'b1) begin
      $display("FAIL ovf_neg: re=%0d ovf=%b, required %0d/1", out_re, out_ovf, exp_lo);
    end else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    frame(8, 16);
    // Junk presented while blocked must not transfer.
    in_valid = 1'b1;
    in_re    = 13'(100);
    in_im    = 13'(-100);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_re !== 6'(4) || out_im !== 6'(8) || out_ovf !== 1'b0) begin
        $display("FAIL bp_hold: cycle %0d valid=%b rdy=%b re=%0d im=%0d ovf=%b, required 1/0/4/8/0",
                 i, out_valid, in_ready, out_re, out_im, out_ovf);
      end else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end else passed++;
  endtask

  task automatic test_stall();
    beat(8, 0);
    beat(8, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL stall_early: gap %0d out_valid=%b, required 0", i, out_valid);
      end else passed++;
    end
    beat(8, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL stall_beat3: out_valid=%b, required 0", out_valid);
    end else passed++;
    beat(8, 0);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 6'(4) || out_im !== 6'(0)) begin
      $display("FAIL stall_result: valid=%b re=%0d im=%0d, required 1/4/0", out_valid, out_re, out_im);
    end else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    beat(64, 64);
    beat(64, 64);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_re !== 6'(0) || out_im !== 6'(0) || out_ovf !== 1'b0) begin
      $display("FAIL rst_mid_outputs: valid=%b re=%0d im=%0d ovf=%b, required 0/0/0/0",
               out_valid, out_re, out_im, out_ovf);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(8, 0);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 6'(4) || out_im !== 6'(0)) begin
      $display("FAIL rst_mid_result: valid=%b re=%0d im=%0d, required 1/4/0", out_valid, out_re, out_im);
    end else passed++;
    // Reset while a result is pending drops it.
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_re !== 6'(0)) begin
      $display("FAIL rst_out_drop: valid=%b re=%0d, required 0/0", out_valid, out_re);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL rst_out_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    frame(48, -32);
    @(negedge clk);
    frame(-48, 32);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 6'(-24) || out_im !== 6'(16)) begin
      $display("FAIL b2b_second: valid=%b re=%0d im=%0d, required 1/-24/16", out_valid, out_re, out_im);
    end else passed++;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
